// File: rtl/lane_mem_arbiter_if.sv
// Lane-side and memory-side bundles for lane_mem_arbiter.
// Lane fields are packed per lane, lane g at [W*g +: W].
interface lane_mem_arbiter_lane_if #(
   parameter int NUM_LANES     = 4,
   parameter int DATA_WIDTH    = 64,
   parameter int LOGSIZE_WIDTH = 3
);
   logic [NUM_LANES-1:0]               lane_a_valid;
   logic [NUM_LANES-1:0]               lane_a_ready;
   logic [DATA_WIDTH*NUM_LANES-1:0]    lane_a_address;
   logic [NUM_LANES-1:0]               lane_a_is_store;
   logic [LOGSIZE_WIDTH*NUM_LANES-1:0] lane_a_size;
   logic [DATA_WIDTH*NUM_LANES-1:0]    lane_a_data;
   logic [NUM_LANES-1:0]               lane_d_valid;
   logic [NUM_LANES-1:0]               lane_d_ready;
   logic [NUM_LANES-1:0]               lane_d_is_store;
   logic [LOGSIZE_WIDTH*NUM_LANES-1:0] lane_d_size;
   logic [DATA_WIDTH*NUM_LANES-1:0]    lane_d_data;

   modport master (
      output lane_a_valid, lane_a_address, lane_a_is_store,
      output lane_a_size, lane_a_data, lane_d_ready,
      input  lane_a_ready, lane_d_valid, lane_d_is_store,
      input  lane_d_size, lane_d_data
   );

   modport slave (
      input  lane_a_valid, lane_a_address, lane_a_is_store,
      input  lane_a_size, lane_a_data, lane_d_ready,
      output lane_a_ready, lane_d_valid, lane_d_is_store,
      output lane_d_size, lane_d_data
   );
endinterface

interface lane_mem_arbiter_mem_if #(
   parameter int NUM_LANES     = 4,
   parameter int DATA_WIDTH    = 64,
   parameter int LOGSIZE_WIDTH = 3
);
   localparam int SRC_W = $clog2(NUM_LANES);

   logic                     mem_a_valid;
   logic                     mem_a_ready;
   logic [DATA_WIDTH-1:0]    mem_a_address;
   logic                     mem_a_is_store;
   logic [LOGSIZE_WIDTH-1:0] mem_a_size;
   logic [DATA_WIDTH-1:0]    mem_a_data;
   logic [SRC_W-1:0]         mem_a_source;
   logic                     mem_d_valid;
   logic                     mem_d_ready;
   logic                     mem_d_is_store;
   logic [LOGSIZE_WIDTH-1:0] mem_d_size;
   logic [DATA_WIDTH-1:0]    mem_d_data;

   modport master (
      output mem_a_valid, mem_a_address, mem_a_is_store,
      output mem_a_size, mem_a_data, mem_a_source, mem_d_ready,
      input  mem_a_ready, mem_d_valid, mem_d_is_store,
      input  mem_d_size, mem_d_data
   );

   modport slave (
      input  mem_a_valid, mem_a_address, mem_a_is_store,
      input  mem_a_size, mem_a_data, mem_a_source, mem_d_ready,
      output mem_a_ready, mem_d_valid, mem_d_is_store,
      output mem_d_size, mem_d_data
   );
endinterface

// File: rtl/lane_mem_arbiter.sv
// Round-robin arbiter sharing one in-order memory port among lanes,
// with an ID FIFO steering responses back to the requesting lane.
module lane_mem_arbiter #(
   parameter int NUM_LANES     = 4,
   parameter int DATA_WIDTH    = 64,
   parameter int LOGSIZE_WIDTH = 3,
   parameter int MAX_INFLIGHT  = 8
) (
   input  logic                               clock,
   input  logic                               reset_n,
   lane_mem_arbiter_lane_if.slave             lane,
   lane_mem_arbiter_mem_if.master             mem,
   output logic                               inflight,
   output logic [$clog2(MAX_INFLIGHT+1)-1:0]  outstanding,
   output logic                               protocol_error
);
   localparam int SRC_W = $clog2(NUM_LANES);
   localparam int PTR_W = $clog2(MAX_INFLIGHT);
   localparam int CNT_W = $clog2(MAX_INFLIGHT+1);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t           state_q;
   logic [SRC_W-1:0] rr_q;
   logic [SRC_W-1:0] lock_q;
   logic [SRC_W-1:0] fifo_q [MAX_INFLIGHT];
   logic [PTR_W-1:0] wr_q;
   logic [PTR_W-1:0] rd_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             err_q;

   logic             found;
   logic [SRC_W-1:0] scan;
   logic [SRC_W-1:0] cand;
   logic [SRC_W-1:0] grant;
   logic [SRC_W-1:0] head;
   logic             full;
   logic             empty;
   logic             req_v;
   logic             a_valid;
   logic             a_fire;
   logic             d_fire;
   int               idx;

   function automatic logic [SRC_W-1:0] nxt(input logic [SRC_W-1:0] g);
      return (g == SRC_W'(NUM_LANES-1)) ? '0 : g + 1'b1;
   endfunction

   // First valid lane at or after the round-robin pointer.
   always_comb begin
      found = 1'b0;
      scan  = rr_q;
      idx   = 0;
      cand  = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         idx = int'(rr_q) + i;
         if (idx >= NUM_LANES) idx = idx - NUM_LANES;
         cand = SRC_W'(idx);
         if (!found && lane.lane_a_valid[cand]) begin
            found = 1'b1;
            scan  = cand;
         end
      end
   end

   assign grant = (state_q == HOLD) ? lock_q : scan;
   assign full  = (cnt_q == CNT_W'(MAX_INFLIGHT));
   assign empty = (cnt_q == '0);
   assign head  = fifo_q[rd_q];

   assign req_v   = (state_q == HOLD) ? lane.lane_a_valid[lock_q] : found;
   assign a_valid = reset_n & ~full & req_v;
   assign a_fire  = a_valid & mem.mem_a_ready;

   assign mem.mem_a_valid    = a_valid;
   assign mem.mem_a_source   = grant;
   assign mem.mem_a_address  = lane.lane_a_address[DATA_WIDTH*grant +: DATA_WIDTH];
   assign mem.mem_a_data     = lane.lane_a_data[DATA_WIDTH*grant +: DATA_WIDTH];
   assign mem.mem_a_size     = lane.lane_a_size[LOGSIZE_WIDTH*grant +: LOGSIZE_WIDTH];
   assign mem.mem_a_is_store = lane.lane_a_is_store[grant];

   assign mem.mem_d_ready = ~empty & lane.lane_d_ready[head];
   assign d_fire          = mem.mem_d_valid & mem.mem_d_ready;

   always_comb begin
      lane.lane_a_ready = '0;
      lane.lane_d_valid = '0;
      for (int g = 0; g < NUM_LANES; g++) begin
         lane.lane_a_ready[g] = a_fire && (grant == SRC_W'(g));
         lane.lane_d_valid[g] = !empty && mem.mem_d_valid && (head == SRC_W'(g));
      end
   end

   assign lane.lane_d_is_store = {NUM_LANES{mem.mem_d_is_store}};
   assign lane.lane_d_size     = {NUM_LANES{mem.mem_d_size}};
   assign lane.lane_d_data     = {NUM_LANES{mem.mem_d_data}};

   always_comb begin
      cnt_d = cnt_q;
      if (a_fire && !d_fire) cnt_d = cnt_q + 1'b1;
      else if (!a_fire && d_fire) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         rr_q    <= '0;
         lock_q  <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (a_fire) begin
                  rr_q <= nxt(grant);
               end else if (a_valid) begin
                  state_q <= HOLD;
                  lock_q  <= grant;
               end
            end
            HOLD: begin
               if (a_fire) begin
                  rr_q    <= nxt(lock_q);
                  state_q <= IDLE;
               end else if (!lane.lane_a_valid[lock_q]) begin
                  err_q   <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
         if (a_fire) wr_q <= wr_q + 1'b1;
         if (d_fire) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_d;
         if (mem.mem_d_valid && empty) err_q <= 1'b1;
      end
   end

   // Source IDs need no reset: the count gates every read.
   always_ff @(posedge clock) begin
      if (a_fire) fifo_q[wr_q] <= grant;
   end

   assign outstanding    = cnt_q;
   assign inflight       = ~empty;
   assign protocol_error = err_q;
endmodule

// File: tb/tb_lane_mem_arbiter.sv
// Bench for lane_mem_arbiter: directed scenarios plus random traffic
// checked against a queue-based model of arbitration and routing.
module tb_lane_mem_arbiter;
   localparam int N    = 4;
   localparam int DW   = 64;
   localparam int LW   = 3;
   localparam int MAXI = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       inflight;
   logic [3:0] outstanding;
   logic       perr;

   int total = 0;
   int bad   = 0;

   int q[$];
   int rr;
   int hold;
   bit err;

   lane_mem_arbiter_lane_if #(.NUM_LANES(N), .DATA_WIDTH(DW), .LOGSIZE_WIDTH(LW)) lif ();
   lane_mem_arbiter_mem_if  #(.NUM_LANES(N), .DATA_WIDTH(DW), .LOGSIZE_WIDTH(LW)) mif ();

   lane_mem_arbiter #(
      .NUM_LANES(N), .DATA_WIDTH(DW), .LOGSIZE_WIDTH(LW), .MAX_INFLIGHT(MAXI)
   ) dut (
      .clock(clk),
      .reset_n(rst_n),
      .lane(lif),
      .mem(mif),
      .inflight(inflight),
      .outstanding(outstanding),
      .protocol_error(perr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      rr   = 0;
      hold = -1;
      err  = 1'b0;
   endtask

   task automatic rand_fields(input int keep);
      for (int g = 0; g < N; g++) begin
         if (g != keep) begin
            lif.lane_a_address[DW*g +: DW] = {$urandom, $urandom};
            lif.lane_a_data[DW*g +: DW]    = {$urandom, $urandom};
            lif.lane_a_size[LW*g +: LW]    = LW'($urandom_range(0, 7));
            lif.lane_a_is_store[g]         = 1'($urandom_range(0, 1));
         end
      end
   endtask

   // One clock: compare outputs with the model, then advance the model.
   task automatic step(input string tag);
      int g;
      bit av;
      bit afire;
      bit dfire;
      bit was_empty;
      logic [N-1:0] exp_ar;
      logic [N-1:0] exp_dv;
      logic exp_dr;
      #1;
      g = -1;
      if (hold >= 0) g = hold;
      else
         for (int i = 0; i < N; i++)
            if (g < 0 && lif.lane_a_valid[(rr + i) % N]) g = (rr + i) % N;
      av     = (q.size() < MAXI) && (g >= 0) && lif.lane_a_valid[g];
      afire  = av && mif.mem_a_ready;
      exp_ar = '0;
      if (afire) exp_ar[g] = 1'b1;
      was_empty = (q.size() == 0);
      exp_dr = !was_empty && lif.lane_d_ready[q[0]];
      dfire  = mif.mem_d_valid && exp_dr;
      exp_dv = '0;
      if (!was_empty && mif.mem_d_valid) exp_dv[q[0]] = 1'b1;

      chk({tag, ".a_valid"}, mif.mem_a_valid, av);
      chk({tag, ".a_ready"}, lif.lane_a_ready, exp_ar);
      if (av) begin
         chk({tag, ".src"}, mif.mem_a_source, g);
         chk({tag, ".addr"}, mif.mem_a_address, lif.lane_a_address[DW*g +: DW]);
         chk({tag, ".data"}, mif.mem_a_data, lif.lane_a_data[DW*g +: DW]);
         chk({tag, ".size"}, mif.mem_a_size, lif.lane_a_size[LW*g +: LW]);
         chk({tag, ".st"}, mif.mem_a_is_store, lif.lane_a_is_store[g]);
      end
      chk({tag, ".d_ready"}, mif.mem_d_ready, exp_dr);
      chk({tag, ".d_valid"}, lif.lane_d_valid, exp_dv);
      chk({tag, ".d_data"}, lif.lane_d_data, {N{mif.mem_d_data}});
      chk({tag, ".d_size"}, lif.lane_d_size, {N{mif.mem_d_size}});
      chk({tag, ".outst"}, outstanding, q.size());
      chk({tag, ".infl"}, inflight, q.size() != 0);
      chk({tag, ".perr"}, perr, err);

      @(posedge clk);
      if (mif.mem_d_valid && was_empty) err = 1'b1;
      if (dfire) void'(q.pop_front());
      if (afire) begin
         q.push_back(g);
         rr   = (g + 1) % N;
         hold = -1;
      end else if (hold >= 0) begin
         if (!lif.lane_a_valid[hold]) begin
            err  = 1'b1;
            hold = -1;
         end
      end else if (av) begin
         hold = g;
      end
      @(negedge clk);
   endtask

   task automatic drain(input string tag);
      lif.lane_a_valid = '0;
      lif.lane_d_ready = '1;
      for (int i = 0; i < 20 && q.size() > 0; i++) begin
         mif.mem_d_valid = 1'b1;
         mif.mem_d_data  = {$urandom, $urandom};
         step(tag);
      end
      mif.mem_d_valid = 1'b0;
      #1;
      chk({tag, ".empty"}, outstanding, 0);
   endtask

   initial begin
      rst_n               = 1'b0;
      lif.lane_a_valid    = '1;
      lif.lane_d_ready    = '1;
      lif.lane_a_is_store = '0;
      lif.lane_a_address  = '0;
      lif.lane_a_data     = '0;
      lif.lane_a_size     = '0;
      mif.mem_a_ready     = 1'b1;
      mif.mem_d_valid     = 1'b0;
      mif.mem_d_is_store  = 1'b0;
      mif.mem_d_size      = '0;
      mif.mem_d_data      = '0;
      rand_fields(-1);
      model_reset();

      #12;
      chk("rst.a_valid", mif.mem_a_valid, 0);
      chk("rst.a_ready", lif.lane_a_ready, 0);
      chk("rst.d_valid", lif.lane_d_valid, 0);
      chk("rst.d_ready", mif.mem_d_ready, 0);
      chk("rst.outst", outstanding, 0);
      chk("rst.perr", perr, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Round robin over all-valid lanes.
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t1.grant", mif.mem_a_source, i % N);
         chk("t1.count", outstanding, i);
         step("t1");
      end
      #1;
      chk("t1.final", outstanding, 5);
      drain("t1d");

      // Backpressure holds lane 2 even after lane 0 asks.
      mif.mem_a_ready  = 1'b0;
      lif.lane_a_valid = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) lif.lane_a_valid = 4'b0101;
         #1;
         chk("t2.src", mif.mem_a_source, 2);
         chk("t2.addr", mif.mem_a_address, lif.lane_a_address[DW*2 +: DW]);
         step("t2");
      end
      mif.mem_a_ready = 1'b1;
      #1;
      chk("t2.acc", lif.lane_a_ready, 4'b0100);
      step("t2");
      #1;
      chk("t2.next", mif.mem_a_source, 0);
      step("t2");
      drain("t2d");

      // Fill to capacity; a pop does not admit a push in the same cycle.
      for (int i = 0; i < MAXI; i++) begin
         lif.lane_a_valid = N'($urandom_range(1, 15));
         step("t3f");
      end
      lif.lane_a_valid = '1;
      #1;
      chk("t3.full", outstanding, MAXI);
      step("t3");
      step("t3");
      mif.mem_d_valid = 1'b1;
      #1;
      chk("t3.popblk", lif.lane_a_ready, 0);
      step("t3");
      mif.mem_d_valid = 1'b0;
      #1;
      chk("t3.after", mif.mem_a_valid, 1);
      step("t3");
      drain("t3d");

      // Response steering with a stalled lane 3.
      lif.lane_a_valid = 4'b0010;
      step("t4");
      lif.lane_a_valid = 4'b1000;
      step("t4");
      lif.lane_a_valid = 4'b0010;
      step("t4");
      lif.lane_a_valid = '0;
      mif.mem_d_valid  = 1'b1;
      mif.mem_d_data   = 64'hD0;
      #1;
      chk("t4.d0", lif.lane_d_valid, 4'b0010);
      step("t4");
      mif.mem_d_data   = 64'hD1;
      lif.lane_d_ready = 4'b0111;
      #1;
      chk("t4.stall", mif.mem_d_ready, 0);
      step("t4");
      step("t4");
      lif.lane_d_ready = '1;
      #1;
      chk("t4.d1", lif.lane_d_valid, 4'b1000);
      step("t4");
      mif.mem_d_data = 64'hD2;
      #1;
      chk("t4.d2", lif.lane_d_valid, 4'b0010);
      step("t4");
      mif.mem_d_valid = 1'b0;
      #1;
      chk("t4.empty", outstanding, 0);

      // Simultaneous push and pop, then random mixed traffic.
      lif.lane_a_valid = '1;
      for (int i = 0; i < 4; i++) step("t5f");
      mif.mem_d_valid = 1'b1;
      #1;
      chk("t5.pre", outstanding, 4);
      step("t5");
      #1;
      chk("t5.post", outstanding, 4);
      for (int i = 0; i < 200; i++) begin
         rand_fields(hold);
         lif.lane_a_valid = N'($urandom);
         if (hold >= 0) lif.lane_a_valid[hold] = 1'b1;
         lif.lane_d_ready   = N'($urandom);
         mif.mem_a_ready    = 1'($urandom_range(0, 1));
         mif.mem_d_valid    = (q.size() > 0) && ($urandom_range(0, 2) != 0);
         mif.mem_d_data     = {$urandom, $urandom};
         mif.mem_d_size     = LW'($urandom_range(0, 7));
         mif.mem_d_is_store = 1'($urandom_range(0, 1));
         step("t5r");
      end
      mif.mem_a_ready = 1'b1;
      drain("t5d");
      chk("t5.noerr", perr, 0);

      // Response with nothing outstanding is flagged and sticks.
      mif.mem_d_valid = 1'b1;
      step("t6");
      mif.mem_d_valid = 1'b0;
      #1;
      chk("t6.err", perr, 1);
      lif.lane_a_valid = '1;
      for (int i = 0; i < 3; i++) step("t6f");
      chk("t6.sticky", perr, 1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t6.rst.av", mif.mem_a_valid, 0);
      chk("t6.rst.ar", lif.lane_a_ready, 0);
      chk("t6.rst.dv", lif.lane_d_valid, 0);
      chk("t6.rst.dr", mif.mem_d_ready, 0);
      chk("t6.rst.cnt", outstanding, 0);
      chk("t6.rst.infl", inflight, 0);
      chk("t6.rst.perr", perr, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("t6.first", mif.mem_a_source, 0);
      chk("t6.firstv", mif.mem_a_valid, 1);
      step("t6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
